// File: rtl/imem_port_arbiter.sv
// rtl/imem_port_arbiter.sv - fetch/loader arbiter for the single-ported instruction memory
//
// Purpose:
//   Shares one single-ported instruction memory between the fetch unit and the
//   program loader/debug port. Fetch has fixed priority. A starvation counter
//   forces one loader grant after STARVE_LIMIT blocked loader cycles. Responses
//   are registered and appear exactly one cycle after the grant. Misaligned or
//   out-of-range addresses are granted but never touch memory; they return err=1.
//
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   f_req/f_addr                fetch read request, byte address
//   f_gnt                       fetch accepted this cycle (combinational)
//   f_rvalid/f_rdata/f_err      fetch response, one cycle after f_gnt
//   l_req/l_we/l_addr/l_wdata   loader request, write flag, byte address, write data
//   l_gnt                       loader accepted this cycle (combinational)
//   l_rvalid/l_rdata/l_err      loader response/ack, one cycle after l_gnt
//   m_en/m_we/m_addr/m_wdata    memory enable, write strobe, word address, write data
//   m_rdata                     memory read data (combinational from m_addr)
module imem_port_arbiter #(
   parameter int AW           = 10,
   parameter int DW           = 32,
   parameter int STARVE_LIMIT = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          f_req,
   input  logic [31:0]   f_addr,
   output logic          f_gnt,
   output logic          f_rvalid,
   output logic [DW-1:0] f_rdata,
   output logic          f_err,
   input  logic          l_req,
   input  logic          l_we,
   input  logic [31:0]   l_addr,
   input  logic [DW-1:0] l_wdata,
   output logic          l_gnt,
   output logic          l_rvalid,
   output logic [DW-1:0] l_rdata,
   output logic          l_err,
   output logic          m_en,
   output logic          m_we,
   output logic [AW-1:0] m_addr,
   output logic [DW-1:0] m_wdata,
   input  logic [DW-1:0] m_rdata
);

   typedef enum logic {
      ST_FPRI = 1'b0,
      ST_LPRI = 1'b1
   } state_t;

   localparam int            CW    = $clog2(STARVE_LIMIT + 1);
   localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

   state_t        state_q, state_d;
   logic [CW-1:0] wait_cnt_q, wait_cnt_d;

   logic          f_rvalid_q, f_err_q;
   logic [DW-1:0] f_rdata_q;
   logic          l_rvalid_q, l_err_q;
   logic [DW-1:0] l_rdata_q;

   logic [31:0]   sel_addr;
   logic          sel_ok;
   logic          any_gnt;

   // Word aligned and no bits set above the memory's byte range.
   function automatic logic addr_ok(input logic [31:0] a);
      return (a[1:0] == 2'b00) && ((a >> (AW + 2)) == 32'd0);
   endfunction

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_FPRI;
         wait_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         wait_cnt_q <= wait_cnt_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d    = state_q;
      wait_cnt_d = wait_cnt_q;
      case (state_q)
         ST_FPRI: begin
            // Only a request that is present and refused counts as starvation.
            if (l_req && !l_gnt) begin
               wait_cnt_d = (wait_cnt_q == LIMIT) ? wait_cnt_q : wait_cnt_q + 1'b1;
            end else begin
               wait_cnt_d = '0;
            end
            if (wait_cnt_d == LIMIT) begin
               state_d = ST_LPRI;
            end
         end
         ST_LPRI: begin
            // One cycle of loader priority, used or not, then back to fetch.
            wait_cnt_d = '0;
            state_d    = ST_FPRI;
         end
         default: begin
            wait_cnt_d = '0;
            state_d    = ST_FPRI;
         end
      endcase
   end

   // Grant outputs
   always_comb begin
      f_gnt = 1'b0;
      l_gnt = 1'b0;
      if (!rst) begin
         case (state_q)
            ST_FPRI: begin
               if (f_req) begin
                  f_gnt = 1'b1;
               end else if (l_req) begin
                  l_gnt = 1'b1;
               end
            end
            ST_LPRI: begin
               if (l_req) begin
                  l_gnt = 1'b1;
               end else if (f_req) begin
                  f_gnt = 1'b1;
               end
            end
            default: begin
               f_gnt = 1'b0;
               l_gnt = 1'b0;
            end
         endcase
      end
   end

   // Memory port: bad addresses are granted but never reach memory.
   always_comb begin
      sel_addr = l_gnt ? l_addr : f_addr;
      sel_ok   = addr_ok(sel_addr);
      any_gnt  = f_gnt || l_gnt;
      m_en     = any_gnt && sel_ok;
      m_we     = m_en && l_gnt && l_we;
      m_addr   = m_en ? sel_addr[AW+1:2] : '0;
      m_wdata  = m_we ? l_wdata : '0;
   end

   // Response registers: capture at grant, present one cycle later.
   always_ff @(posedge clk) begin
      if (rst) begin
         f_rvalid_q <= 1'b0;
         f_err_q    <= 1'b0;
         f_rdata_q  <= '0;
         l_rvalid_q <= 1'b0;
         l_err_q    <= 1'b0;
         l_rdata_q  <= '0;
      end else begin
         f_rvalid_q <= f_gnt;
         f_err_q    <= f_gnt && !sel_ok;
         f_rdata_q  <= (f_gnt && sel_ok) ? m_rdata : '0;
         l_rvalid_q <= l_gnt;
         l_err_q    <= l_gnt && !sel_ok;
         l_rdata_q  <= (l_gnt && sel_ok && !l_we) ? m_rdata : '0;
      end
   end

   // A response owed from the cycle before reset is suppressed while rst is high.
   always_comb begin
      f_rvalid = f_rvalid_q && !rst;
      f_err    = f_err_q && !rst;
      f_rdata  = rst ? '0 : f_rdata_q;
      l_rvalid = l_rvalid_q && !rst;
      l_err    = l_err_q && !rst;
      l_rdata  = rst ? '0 : l_rdata_q;
   end

endmodule

// File: tb/tb_imem_port_arbiter.sv
// tb/tb_imem_port_arbiter.sv - scoreboard bench for imem_port_arbiter
module tb_imem_port_arbiter;
   localparam int AW    = 10;
   localparam int DW    = 32;
   localparam int N     = 4;
   localparam int DEPTH = 1 << AW;

   typedef struct {
      int            stamp;
      logic          err;
      logic [DW-1:0] data;
   } resp_t;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          f_req = 1'b0;
   logic [31:0]   f_addr = '0;
   logic          f_gnt, f_rvalid, f_err;
   logic [DW-1:0] f_rdata;
   logic          l_req = 1'b0;
   logic          l_we = 1'b0;
   logic [31:0]   l_addr = '0;
   logic [DW-1:0] l_wdata = '0;
   logic          l_gnt, l_rvalid, l_err;
   logic [DW-1:0] l_rdata;
   logic          m_en, m_we;
   logic [AW-1:0] m_addr;
   logic [DW-1:0] m_wdata, m_rdata;

   logic [DW-1:0] mem     [0:DEPTH-1];
   logic [DW-1:0] ref_mem [0:DEPTH-1];

   resp_t fq[$];
   resp_t lq[$];
   int    blocked = 0;
   int    cyc = 0;
   int    checks = 0;
   int    errors = 0;

   imem_port_arbiter #(.AW(AW), .DW(DW), .STARVE_LIMIT(N)) dut (
      .clk(clk), .rst(rst),
      .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt),
      .f_rvalid(f_rvalid), .f_rdata(f_rdata), .f_err(f_err),
      .l_req(l_req), .l_we(l_we), .l_addr(l_addr), .l_wdata(l_wdata),
      .l_gnt(l_gnt), .l_rvalid(l_rvalid), .l_rdata(l_rdata), .l_err(l_err),
      .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
      .m_rdata(m_rdata)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   assign m_rdata = mem[m_addr];
   always @(posedge clk) if (m_en && m_we) mem[m_addr] <= m_wdata;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic good_addr(input logic [31:0] a);
      return (a[1:0] == 2'b00) && (a < 32'(DEPTH * 4));
   endfunction

   function automatic logic [31:0] rand_addr();
      logic [31:0] a;
      int k;
      k = $urandom_range(0, 9);
      a = 32'($urandom_range(0, DEPTH - 1)) << 2;
      if (k == 0) a[1:0] = 2'($urandom_range(1, 3));
      else if (k == 1) a = a | (32'($urandom_range(1, 255)) << (AW + 2));
      return a;
   endfunction

   // One clock cycle: drive inputs, predict the arbitration outcome from the
   // policy (fetch first unless the loader has waited N refused cycles),
   // check grant/memory outputs, and queue the expected responses.
   task automatic cycle(input logic r, input logic fr, input logic [31:0] fa,
                        input logic lr, input logic lwe, input logic [31:0] la,
                        input logic [DW-1:0] lwd, output logic fg, output logic lg);
      logic        exp_f, exp_l, ok, exp_men, exp_mwe;
      logic [31:0] a;
      int          idx;
      resp_t       e;
      rst = r; f_req = fr; f_addr = fa;
      l_req = lr; l_we = lwe; l_addr = la; l_wdata = lwd;
      @(negedge clk);
      if (r) begin
         chk("rst_f_gnt", f_gnt, 0);
         chk("rst_l_gnt", l_gnt, 0);
         chk("rst_m_en", m_en, 0);
         chk("rst_m_we", m_we, 0);
         chk("rst_f_rvalid", f_rvalid, 0);
         chk("rst_l_rvalid", l_rvalid, 0);
         chk("rst_rdata", {f_rdata, l_rdata}, 0);
         chk("rst_err", {f_err, l_err}, 0);
         fq.delete();
         lq.delete();
         blocked = 0;
         fg = 1'b0;
         lg = 1'b0;
      end else begin
         exp_l = lr && (blocked >= N || !fr);
         exp_f = fr && !exp_l;
         chk("f_gnt", f_gnt, exp_f);
         chk("l_gnt", l_gnt, exp_l);
         a       = exp_l ? la : fa;
         ok      = good_addr(a);
         idx     = int'(a[AW+1:2]);
         exp_men = (exp_f || exp_l) && ok;
         exp_mwe = exp_l && ok && lwe;
         chk("m_en", m_en, exp_men);
         chk("m_we", m_we, exp_mwe);
         if (exp_men) chk("m_addr", m_addr, a[AW+1:2]);
         if (exp_mwe) chk("m_wdata", m_wdata, lwd);
         e.stamp = cyc;
         e.err   = !ok;
         if (exp_f) begin
            e.data = ok ? ref_mem[idx] : '0;
            fq.push_back(e);
         end
         if (exp_l) begin
            e.data = (ok && !lwe) ? ref_mem[idx] : '0;
            lq.push_back(e);
            if (exp_mwe) ref_mem[idx] = lwd;
         end
         blocked = (lr && !exp_l) ? ((blocked < N) ? blocked + 1 : N) : 0;
         fg = exp_f;
         lg = exp_l;
      end
      @(posedge clk);
      #1;
   endtask

   // Monitor: a response is owed exactly one cycle after its grant.
   always @(negedge clk) begin
      resp_t e;
      if (!rst) begin
         if (fq.size() > 0 && fq[0].stamp == cyc - 1) begin
            e = fq.pop_front();
            chk("f_rvalid", f_rvalid, 1);
            chk("f_err", f_err, e.err);
            chk("f_rdata", f_rdata, e.data);
         end else begin
            chk("f_rvalid_idle", f_rvalid, 0);
         end
         if (lq.size() > 0 && lq[0].stamp == cyc - 1) begin
            e = lq.pop_front();
            chk("l_rvalid", l_rvalid, 1);
            chk("l_err", l_err, e.err);
            chk("l_rdata", l_rdata, e.data);
         end else begin
            chk("l_rvalid_idle", l_rvalid, 0);
         end
      end
   end

   initial begin
      logic        fg, lg, pf, pl, rwe;
      logic [31:0] rfa, rla, rwd;
      logic [DW-1:0] mem0;
      int          lg_at, bad;
      for (int i = 0; i < DEPTH; i++) begin
         mem[i]     = $urandom;
         ref_mem[i] = mem[i];
      end
      @(posedge clk);
      #1;
      // Reset with requests present: everything held at zero
      cycle(1, 1, 0, 1, 1, 0, 32'h1234, fg, lg);
      cycle(1, 0, 0, 0, 0, 0, 0, fg, lg);

      // Fetch only, back to back
      cycle(0, 1, 32'h0, 0, 0, 0, 0, fg, lg);
      cycle(0, 1, 32'h4, 0, 0, 0, 0, fg, lg);
      cycle(0, 1, 32'h8, 0, 0, 0, 0, fg, lg);
      cycle(0, 0, 0, 0, 0, 0, 0, fg, lg);

      // Loader write then read back
      cycle(0, 0, 0, 1, 1, 32'h10, 32'hDEADBEEF, fg, lg);
      cycle(0, 0, 0, 1, 0, 32'h10, 0, fg, lg);
      cycle(0, 0, 0, 0, 0, 0, 0, fg, lg);

      // Error addresses; word 0 must survive the out-of-range write
      mem0 = ref_mem[0];
      cycle(0, 1, 32'h2, 0, 0, 0, 0, fg, lg);
      cycle(0, 0, 0, 1, 1, 32'h1000, 32'hA5A5A5A5, fg, lg);
      cycle(0, 0, 0, 0, 0, 0, 0, fg, lg);
      chk("mem0_unchanged", mem[0], mem0);

      // Starvation: loader granted on its (N+1)th requesting cycle
      cycle(1, 0, 0, 0, 0, 0, 0, fg, lg);
      lg_at = -1;
      for (int i = 0; i < 8; i++) begin
         cycle(0, 1, 32'(i * 4), lg_at < 0, 0, 32'h40, 0, fg, lg);
         if (lg) lg_at = i;
      end
      chk("starve_lgnt_cycle", 64'(lg_at), 64'(N));

      // Reset right after a fetch grant drops the response and the count
      cycle(0, 1, 32'h20, 1, 0, 32'h44, 0, fg, lg);
      cycle(0, 1, 32'h24, 1, 0, 32'h44, 0, fg, lg);
      cycle(1, 1, 32'h28, 1, 0, 32'h44, 0, fg, lg);
      for (int i = 0; i < 6; i++) cycle(0, 1, 32'h28, 1, 0, 32'h44, 0, fg, lg);
      cycle(0, 0, 0, 0, 0, 0, 0, fg, lg);

      // Loader drops its request in the loader-priority cycle
      for (int i = 0; i < N; i++) cycle(0, 1, 32'h30, 1, 0, 32'h48, 0, fg, lg);
      cycle(0, 1, 32'h34, 0, 0, 0, 0, fg, lg);
      chk("lpri_drop_fgnt", fg, 1);
      cycle(0, 1, 32'h38, 1, 0, 32'h48, 0, fg, lg);
      chk("back_to_fpri", fg, 1);
      cycle(0, 0, 0, 0, 0, 0, 0, fg, lg);

      // Random traffic; requests held until granted
      pf = 0; pl = 0; rfa = 0; rla = 0; rwe = 0; rwd = 0;
      for (int i = 0; i < 2000; i++) begin
         if (!pf && $urandom_range(0, 99) < 60) begin pf = 1; rfa = rand_addr(); end
         if (!pl && $urandom_range(0, 99) < 40) begin
            pl = 1; rla = rand_addr(); rwe = 1'($urandom_range(0, 1)); rwd = $urandom;
         end
         cycle(0, pf, rfa, pl, rwe, rla, rwd, fg, lg);
         if (fg) pf = 0;
         if (lg) pl = 0;
      end
      cycle(0, 0, 0, 0, 0, 0, 0, fg, lg);
      cycle(0, 0, 0, 0, 0, 0, 0, fg, lg);
      chk("f_queue_drained", 64'(fq.size()), 0);
      chk("l_queue_drained", 64'(lq.size()), 0);
      bad = 0;
      for (int i = 0; i < DEPTH; i++) if (mem[i] !== ref_mem[i]) bad++;
      chk("mem_contents", 64'(bad), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
